shift_mix_addkey: RTL

//  Round stage that consumes the SubBytes result and performs ShiftRows, MixColumns and AddRoundKey.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_mix_column.sv | 13 +
 rtl/shift_mix_addkey.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 round helpers: GF(2^8) xtime, ShiftRows, MixColumns and byte/column indexing.
// Used by the forward round stage and the InvMix stage.
package aes_pkg;

   localparam int         STATE_W  = 128;
   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   // State byte k = s[r][c] with k = r + 4c, byte 0 in the MSBs.
   function automatic int byte_idx(input int r, input int c);
      return r + 4 * c;
   endfunction

   function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] st, input int k);
      return st[STATE_W-1-8*k -: 8];
   endfunction

   function automatic logic [31:0] get_col(input logic [STATE_W-1:0] st, input int c);
      return st[STATE_W-1-32*c -: 32];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
      return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
   endfunction

   function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] st);
      logic [STATE_W-1:0] res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[STATE_W-1-8*byte_idx(r, c) -: 8] = get_byte(st, byte_idx(r, (c + r) % 4));
         end
      end
      return res;
   endfunction

   // Column packed row 0 in the MSBs.
   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic [7:0] poly);
      logic [7:0] t0, t1, t2, t3;
      logic [7:0] d0, d1, d2, d3;
      t0 = col[31:24];
      t1 = col[23:16];
      t2 = col[15:8];
      t3 = col[7:0];
      d0 = xtime(t0, poly);
      d1 = xtime(t1, poly);
      d2 = xtime(t2, poly);
      d3 = xtime(t3, poly);
      return {d0 ^ d1 ^ t1 ^ t2 ^ t3,
              t0 ^ d1 ^ d2 ^ t2 ^ t3,
              t0 ^ t1 ^ d2 ^ d3 ^ t3,
              d0 ^ t0 ^ t1 ^ t2 ^ d3};
   endfunction

endpackage

// File: rtl/aes_mix_column.sv
// One MixColumns column, purely combinational; row 0 in the MSBs.
module aes_mix_column
   import aes_pkg::*;
#(
   parameter logic [7:0] POLY = AES_POLY
) (
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   assign col_o = mix_column(col_i, POLY);

endmodule

// File: rtl/shift_mix_addkey.sv
// AES round stage: ShiftRows, MixColumns (bypassed on the last round), AddRoundKey; one-cycle latency.
// Two-entry skid buffer keeps IN_READY on a flop, so OUT_READY never reaches IN_READY combinationally.
module shift_mix_addkey
   import aes_pkg::*;
#(
   parameter int         DATA_W  = 128,
   parameter logic [7:0] MC_POLY = AES_POLY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   input  logic [DATA_W-1:0] ROUND_KEY,
   input  logic              LAST_ROUND,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUT_DATA
);

   if (DATA_W != STATE_W) begin : g_bad_width
      $error("shift_mix_addkey supports only DATA_W = 128");
   end

   logic [DATA_W-1:0] sr_dat;
   logic [DATA_W-1:0] mc_dat;
   logic [DATA_W-1:0] rnd_dat;

   assign sr_dat = shift_rows(IN_DATA);

   for (genvar c = 0; c < 4; c++) begin : g_col
      aes_mix_column #(
         .POLY (MC_POLY)
      ) u_mix_column (
         .col_i (sr_dat[DATA_W-1-32*c -: 32]),
         .col_o (mc_dat[DATA_W-1-32*c -: 32])
      );
   end

   assign rnd_dat = (LAST_ROUND ? sr_dat : mc_dat) ^ ROUND_KEY;

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] o_dat_q, o_dat_d;
   logic [DATA_W-1:0] s_dat_q, s_dat_d;
   logic              in_rdy_q, in_rdy_d;
   logic              out_vld;
   logic              in_xfer;
   logic              out_xfer;

   assign out_vld  = (state_q != SKID_EMPTY);
   assign in_xfer  = IN_VALID && in_rdy_q;
   assign out_xfer = out_vld && OUT_READY;

   // The round result is only selected on an accepted transfer, so idle-cycle input garbage never lands in state.
   always_comb begin
      state_d = state_q;
      o_dat_d = o_dat_q;
      s_dat_d = s_dat_q;
      case (state_q)
         SKID_EMPTY: begin
            if (in_xfer) begin
               o_dat_d = rnd_dat;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_xfer && out_xfer) begin
               o_dat_d = rnd_dat;
            end else if (in_xfer) begin
               s_dat_d = rnd_dat;
               state_d = SKID_FULL;
            end else if (out_xfer) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_xfer) begin
               o_dat_d = s_dat_q;
               state_d = SKID_ONE;
            end
         end
         default: begin
            state_d = SKID_EMPTY;
         end
      endcase
      in_rdy_d = (state_d != SKID_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SKID_EMPTY;
         o_dat_q  <= '0;
         s_dat_q  <= '0;
         in_rdy_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         o_dat_q  <= o_dat_d;
         s_dat_q  <= s_dat_d;
         in_rdy_q <= in_rdy_d;
      end
   end

   assign IN_READY  = in_rdy_q;
   assign OUT_VALID = out_vld;
   assign OUT_DATA  = o_dat_q;

endmodule
